temp_adc_avg: RTL and testbench
===============================

TEMP_ADC_AVG -- requirements
Module: temp_adc_avg

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 50000, clock cycles between conversion requests (>= 4).
REQ-002 SHALL have parameter AVG_LOG2, default 3, log2 of samples averaged per output (1..6).
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum cycles to wait for end-of-conversion.
REQ-004 SHALL have port: clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: adc_eoc  in  1  ADC end-of-conversion strobe, adc_data valid while high.
REQ-007 SHALL have port: adc_data  in  12  raw ADC temperature code.
REQ-008 SHALL have port: adc_start  out  1  conversion request, one-cycle pulse.
REQ-009 SHALL have port: temp  out  12  averaged temperature code; feeds the threshold/display stage.
REQ-010 SHALL have port: temp_valid  out  1  one-cycle pulse when temp updates.
REQ-011 SHALL have port: timeout_err  out  1  sticky, set on conversion timeout.

Function
REQ-012 SHALL run a free-running period counter 0..SAMPLE_PERIOD-1, producing a tick at terminal count.
REQ-013 SHALL implement an FSM with states IDLE, START, WAIT, ACC.
REQ-014 SHALL move IDLE->START on tick; START drives adc_start=1 for exactly one cycle, then WAIT.
REQ-015 SHALL, in WAIT, capture adc_data on adc_eoc=1 and go to ACC; the wait counter clears on entry to WAIT.
REQ-016 SHALL add the captured sample to an accumulator of width 12+AVG_LOG2 (no overflow possible) and increment the sample count in ACC.
REQ-017 SHALL, when the count reaches 2^AVG_LOG2, register temp = accumulator >> AVG_LOG2 (floor), pulse temp_valid, and clear the accumulator and count.
REQ-018 SHALL exhibit latency: eoc sampled at edge k; temp/temp_valid updated at edge k+2.
REQ-019 SHALL return ACC->IDLE in all cases.
REQ-020 SHALL, if TIMEOUT cycles elapse in WAIT without eoc, set timeout_err, discard the partial accumulation (accumulator and count cleared), and go to IDLE.
REQ-021 SHALL give eoc priority over timeout when both occur in the same cycle (sample accepted, no error).
REQ-022 SHALL ignore adc_eoc outside WAIT.
REQ-023 SHALL drop ticks arriving outside IDLE (no queueing).
REQ-024 SHALL hold temp between updates.

Reset
REQ-025 SHALL, on rst, clear the FSM to IDLE, the period/wait counters, accumulator and sample count to 0, and set adc_start=0, temp_valid=0, timeout_err=0.
REQ-026 SHALL reset temp to 12'hFFF (coolest code, so the downstream over-temperature compare stays inactive).
REQ-027 SHALL make a reset mid-accumulation discard all partial samples.

Configuration
REQ-028 SHALL, with TEMP_MINMAX_EN defined, add outputs temp_min and temp_max (12 bits each; reset FFF/000), updated on every temp_valid with the new temp.
REQ-029 SHALL, without TEMP_MINMAX_EN, have neither these ports nor their registers.

Structure
REQ-030 SHALL place the FSM state enum, the 12-bit temp code width and the temp reset constant 12'hFFF in shared package temp_pkg.
REQ-031 SHALL implement the period counter as sub-module tick_gen (parameter PERIOD, one-cycle tick output).

Verification (SAMPLE_PERIOD=16, AVG_LOG2=2, TIMEOUT=8)
REQ-032 SHALL verify: samples 100,200,300,400 -> temp=250, single temp_valid two cycles after the 4th eoc; adc_start one cycle per period.
REQ-033 SHALL verify: samples 4095 x4 -> temp=4095; samples 1,1,1,2 -> temp=1 (floor).
REQ-034 SHALL verify: no eoc for 8 cycles after a start -> timeout_err=1 and stays set; the next 4 samples of 1000 -> temp=1000 (prior partial discarded).
REQ-035 SHALL verify: eoc held high during IDLE -> ignored; eoc on the 8th WAIT cycle -> accepted, timeout_err stays 0.
REQ-036 SHALL verify: rst after 2 samples -> temp=FFF, temp_valid=0; the next average uses only post-reset samples.
REQ-037 SHALL verify with TEMP_MINMAX_EN: averages 3000, 3700, 3650 -> temp_min=3000, temp_max=3700.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared definitions for the temperature ADC averager: code width, reset code
// and the sequencing FSM states.
package temp_pkg;

    localparam int TEMP_W = 12;

    // Coolest code, keeps the downstream over-temperature compare inactive.
    localparam logic [TEMP_W-1:0] TEMP_RST = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_ACC
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running period counter 0..PERIOD-1; tick is high for the one cycle
// the counter sits at terminal count.
module tick_gen #(
    parameter int PERIOD = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/temp_adc_avg.sv
// Periodic temperature ADC sequencer with boxcar averaging of 2^AVG_LOG2 samples.
// Optional build macro TEMP_MINMAX_EN adds running min/max of the averaged code.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a period tick
// START   | adc_start high for this single cycle
// WAIT    | waiting for adc_eoc, bounded by TIMEOUT cycles
// ACC     | add captured sample to accumulator, always back to IDLE
module temp_adc_avg
    import temp_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 50000,
    parameter int AVG_LOG2      = 3,
    parameter int TIMEOUT       = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_eoc,
    input  logic [TEMP_W-1:0] adc_data,
    output logic              adc_start,
    output logic [TEMP_W-1:0] temp,
    output logic              temp_valid,
    output logic              timeout_err
`ifdef TEMP_MINMAX_EN
    ,
    output logic [TEMP_W-1:0] temp_min,
    output logic [TEMP_W-1:0] temp_max
`endif
);

    localparam int ACC_W  = TEMP_W + AVG_LOG2;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state;
    logic                tick;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [TEMP_W-1:0]   sample;
    logic [ACC_W-1:0]    acc;
    logic [AVG_LOG2-1:0] sample_cnt;
    logic                avg_done;
    logic [TEMP_W-1:0]   avg_val;

    tick_gen #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign avg_val = acc[ACC_W-1:AVG_LOG2];

    // avg_done is raised in ACC on the last sample of a block so the result
    // lands one cycle later, after the final add has settled in acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            sample      <= '0;
            acc         <= '0;
            sample_cnt  <= '0;
            avg_done    <= 1'b0;
            adc_start   <= 1'b0;
            temp        <= TEMP_RST;
            temp_valid  <= 1'b0;
            timeout_err <= 1'b0;
`ifdef TEMP_MINMAX_EN
            temp_min    <= TEMP_RST;
            temp_max    <= '0;
`endif
        end else begin
            adc_start  <= 1'b0;
            temp_valid <= 1'b0;
            avg_done   <= 1'b0;

            if (avg_done) begin
                temp       <= avg_val;
                temp_valid <= 1'b1;
                acc        <= '0;
                sample_cnt <= '0;
`ifdef TEMP_MINMAX_EN
                if (avg_val < temp_min) temp_min <= avg_val;
                if (avg_val > temp_max) temp_max <= avg_val;
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state     <= ST_START;
                        adc_start <= 1'b1;
                    end
                end
                ST_START: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    // eoc wins over a timeout landing in the same cycle
                    if (adc_eoc) begin
                        sample <= adc_data;
                        state  <= ST_ACC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        acc         <= '0;
                        sample_cnt  <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ACC: begin
                    acc        <= acc + ACC_W'(sample);
                    sample_cnt <= sample_cnt + 1'b1;
                    avg_done   <= &sample_cnt;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_adc_avg.sv
// Self-checking bench for temp_adc_avg: a scoreboard of expected averages is
// filled as samples are driven and drained as temp_valid pulses appear.
module tb_temp_adc_avg;

    localparam int SP = 16;
    localparam int AL = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_eoc;
    logic [11:0] adc_data;
    logic        adc_start;
    logic [11:0] temp;
    logic        temp_valid;
    logic        timeout_err;
`ifdef TEMP_MINMAX_EN
    logic [11:0] temp_min;
    logic [11:0] temp_max;
`endif

    temp_adc_avg #(
        .SAMPLE_PERIOD (SP),
        .AVG_LOG2      (AL),
        .TIMEOUT       (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adc_eoc     (adc_eoc),
        .adc_data    (adc_data),
        .adc_start   (adc_start),
        .temp        (temp),
        .temp_valid  (temp_valid),
        .timeout_err (timeout_err)
`ifdef TEMP_MINMAX_EN
        ,
        .temp_min    (temp_min),
        .temp_max    (temp_max)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] t;
        int          eoc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_acc  = 0;
    int   m_cnt  = 0;
    logic m_err  = 1'b0;
    logic [11:0] m_last = 12'hFFF;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    // One conversion: wait for adc_start, then assert eoc on WAIT cycle dly+1.
    // dly >= TO means no eoc at all, so the conversion must time out.
    task automatic conv(input logic [11:0] d, input int dly);
        int   budget;
        exp_t e;
        budget = 0;
        while (adc_start !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (adc_start !== 1'b1) begin
            chk_val("start_wait", adc_start, 1);
            return;
        end
        @(negedge clk);
        if (dly < TO) begin
            repeat (dly) @(negedge clk);
            adc_eoc  = 1'b1;
            adc_data = d;
            m_acc += int'(d);
            m_cnt++;
            if (m_cnt == (1 << AL)) begin
                e.t       = 12'(m_acc >> AL);
                e.eoc_cyc = cyc + 1;
                sb.push_back(e);
                m_last = e.t;
                m_acc  = 0;
                m_cnt  = 0;
            end
            @(negedge clk);
            adc_eoc  = 1'b0;
            adc_data = '0;
            chk_val("err_after_eoc", timeout_err, m_err);
        end else begin
            repeat (TO - 1) @(negedge clk);
            chk_val("timeout_early", timeout_err, m_err);
            @(negedge clk);
            m_err = 1'b1;
            m_acc = 0;
            m_cnt = 0;
            chk_val("timeout_set", timeout_err, 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_val("rst_temp", temp, 12'hFFF);
        chk_val("rst_valid", temp_valid, 0);
        chk_val("rst_start", adc_start, 0);
        chk_val("rst_err", timeout_err, 0);
        rst = 1'b0;
        m_acc  = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_last = 12'hFFF;
    endtask

    int   last_start = -1;
    logic prev_start = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            last_start = -1;
            prev_start = 1'b0;
        end else begin
            if (adc_start) begin
                chk_val("start_width", prev_start, 0);
                if (last_start >= 0) chk_val("start_period", cyc - last_start, SP);
                last_start = cyc;
            end
            prev_start = adc_start;
            if (temp_valid) begin
                chk_val("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk_val("temp", temp, mon_e.t);
                    chk_val("valid_latency", cyc, mon_e.eoc_cyc + 2);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        adc_eoc  = 1'b0;
        adc_data = '0;
        @(negedge clk);
        do_reset();
`ifdef TEMP_MINMAX_EN
        chk_val("rst_min", temp_min, 12'hFFF);
        chk_val("rst_max", temp_max, 0);
`endif

        // basic average and hold between updates
        conv(12'd100, 0);
        conv(12'd200, 2);
        conv(12'd300, 3);
        conv(12'd400, 1);
        repeat (4) @(negedge clk);
        chk_val("temp_hold", temp, m_last);

        // full scale, then floor rounding
        for (int i = 0; i < 4; i++) conv(12'd4095, i);
        conv(12'd1, 0);
        conv(12'd1, 0);
        conv(12'd1, 0);
        conv(12'd2, 0);

        // eoc held during IDLE is ignored; eoc on the last WAIT cycle is accepted
        adc_eoc  = 1'b1;
        adc_data = 12'd3333;
        repeat (3) @(negedge clk);
        adc_eoc  = 1'b0;
        adc_data = '0;
        conv(12'd10, 7);
        conv(12'd20, 7);
        conv(12'd30, 7);
        conv(12'd40, 7);
        chk_val("no_err_boundary", timeout_err, 0);

        // timeout discards partial accumulation, error is sticky
        conv(12'd500, 0);
        conv(12'd500, 0);
        conv(12'd0, TO);
        for (int i = 0; i < 4; i++) conv(12'd1000, 1);
        repeat (4) @(negedge clk);
        chk_val("err_sticky", timeout_err, 1);
        chk_val("temp_after_to", temp, m_last);

        // reset mid-accumulation
        conv(12'd700, 0);
        conv(12'd700, 0);
        do_reset();
        conv(12'd40, 0);
        conv(12'd40, 1);
        conv(12'd40, 2);
        conv(12'd44, 3);
        repeat (4) @(negedge clk);
        chk_val("temp_post_rst", temp, m_last);

`ifdef TEMP_MINMAX_EN
        do_reset();
        for (int i = 0; i < 4; i++) conv(12'd3000, 0);
        for (int i = 0; i < 4; i++) conv(12'd3700, 0);
        for (int i = 0; i < 4; i++) conv(12'd3650, 0);
        repeat (4) @(negedge clk);
        chk_val("temp_min", temp_min, 3000);
        chk_val("temp_max", temp_max, 3700);
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk_val("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
